dmem_bus_ctrl: RTL
==================

// Module: dmem_bus_ctrl
// PURPOSE
//  Sequential data-memory bus controller; sits directly downstream of the mem stage.
//  Consumes the mem stage's load/store request (ce, r_ena, raddr/waddr, data, sel).
//  Runs one valid/ready transaction on the data bus and aligns byte lanes both ways.
//  Returns the right-justified read data to the mem stage, which does sign/zero extension.
//  Stalls the pipeline until the access completes.
// PARAMETERS
//  ADDR_W        64   request/bus address width
//  DATA_W        64   data width; fixed 8 byte lanes, so DATA_W must be 64
//  RESP_TIMEOUT  16   max cycles in RESP waiting bus_rvalid_i before abort (>=1)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active-low
//  ce_ram_i       in   1       request present this cycle (from mem stage)
//  mem_r_ena_i    in   1       1=load, 0=store (valid with ce_ram_i)
//  mem_raddr_i    in   ADDR_W  load byte address
//  mem_waddr_i    in   ADDR_W  store byte address
//  mem_data_i     in   DATA_W  store data, right-justified
//  mem_sel_i      in   8       byte mask, right-justified: 0x01/0x03/0x0F/0xFF
//  hold_i         in   1       other-source pipeline stall; keeps DONE result stable
//  mem_data_ram_o out  DATA_W  read data, shifted so addressed byte is [7:0]
//  stall_req_o    out  1       1 = hold pipeline, access in flight
//  err_o          out  1       1 in DONE if access aborted (timeout / misalign)
//  misalign_o     out  1       1 in DONE if aborted for misalignment
//  bus_valid_o    out  1       request valid
//  bus_ready_i    in   1       request accepted when valid&ready
//  bus_we_o       out  1       1=write
//  bus_addr_o     out  ADDR_W  {addr[ADDR_W-1:3],3'b000}
//  bus_wdata_o    out  DATA_W  mem_data_i << (8*addr[2:0])
//  bus_wstrb_o    out  8       (mem_sel_i << addr[2:0]), truncated to 8 bits
//  bus_rvalid_i   in   1       response for reads and writes (write ack)
//  bus_rdata_i    in   DATA_W  read data, valid with bus_rvalid_i
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, all registered outputs 0.
//    Includes bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
//    mem_data_ram_o, err_o, misalign_o, and the timeout counter.
//    Reset mid-transaction drops it silently; rvalid arriving in IDLE is ignored.
//  - stall_req_o = ce_ram_i & (state==IDLE) | (state==REQ) | (state==RESP). Combinational.
//  - Address used = mem_r_ena_i ? mem_raddr_i : mem_waddr_i.
//  - FSM:
//    IDLE: on ce_ram_i, latch addr, lane-shifted wdata/wstrb and we=~mem_r_ena_i.
//          Set bus_valid_o=1, clear err_o/misalign_o, go REQ.
//    REQ:  bus_valid_o held with stable payload until bus_ready_i.
//          On handshake, bus_valid_o<=0, counter<=0, go RESP. No timeout in REQ.
//    RESP: on bus_rvalid_i, capture bus_rdata_i >> (8*addr[2:0]) into
//          mem_data_ram_o (writes also capture; mem stage ignores it), go DONE.
//          Else counter++. At counter==RESP_TIMEOUT-1 without rvalid:
//          err_o<=1, mem_data_ram_o<=0, go DONE.
//          rvalid on the same cycle as the limit wins (no error).
//    DONE: stall_req_o=0, outputs stable. Go IDLE when hold_i==0; stay while hold_i==1.
//  - Latency: ready and rvalid both first possible -> 3 stall cycles (IDLE, REQ, RESP),
//    data visible in cycle 4 (DONE).
//  - Back-to-back: a new request is sampled only in IDLE; none accepted in DONE.
//  - At most one outstanding transaction; rvalid outside RESP is ignored.
// CONFIGURATION
//  DMEM_MISALIGN_CHK_EN defined:
//    - IDLE checks alignment: sel 0x03 needs addr[0]==0; 0x0F needs addr[1:0]==0;
//      0xFF needs addr[2:0]==0.
//    - Misaligned -> no bus request; go straight to DONE with err_o=1,
//      misalign_o=1, mem_data_ram_o=0.
//    - Stall is 1 cycle.
//  Not defined:
//    - No check; misalign_o tied 0.
//    - Lanes beyond byte 7 are dropped by wstrb truncation; read returns the shifted word.
// TESTING
//  1 LD addr 0x80000010, sel 0xFF, ready/rvalid immediate, rdata 0x1122334455667788
//    -> bus_addr 0x80000010, wstrb 0xFF, stall 3 cycles, mem_data_ram_o 0x1122334455667788.
//  2 SB addr 0x80000005, data 0xAB -> bus_we 1, wstrb 0x20,
//    bus_wdata 0x0000AB0000000000, bus_addr 0x80000000; DONE after rvalid.
//  3 LH addr 0x80000006, rdata 0xBEEF000000000000, ready delayed 4 cycles
//    -> bus_valid/payload stable 5 cycles; mem_data_ram_o 0x000000000000BEEF.
//  4 LW with no rvalid, RESP_TIMEOUT=16 -> exactly 16 RESP cycles,
//    err_o=1, data 0; rvalid arriving later is ignored in IDLE.
//  5 rst low in RESP -> bus_valid_o/stall drop immediately, state IDLE;
//    hold_i=1 in DONE for 3 cycles -> data held, no re-issue.
//  6 DMEM_MISALIGN_CHK_EN: LW addr 0x80000002 -> no bus_valid_o,
//    1-cycle stall, err_o=1, misalign_o=1; without macro -> wstrb 0x3C, normal access.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns one mem-stage load/store into a single valid/ready bus
// transaction with byte-lane alignment. Define DMEM_MISALIGN_CHK_EN to abort misaligned accesses.
module dmem_bus_ctrl #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_ram_i,
  input  logic              mem_r_ena_i,
  input  logic [ADDR_W-1:0] mem_raddr_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [7:0]        mem_sel_i,
  input  logic              hold_i,
  output logic [DATA_W-1:0] mem_data_ram_o,
  output logic              stall_req_o,
  output logic              err_o,
  output logic              misalign_o,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [7:0]        bus_wstrb_o,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int unsigned CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        off;
  logic [ADDR_W-1:0] addr_c;
  logic [2:0]        req_off_c;
  logic              misaligned_c;

  assign addr_c      = mem_r_ena_i ? mem_raddr_i : mem_waddr_i;
  assign req_off_c   = addr_c[2:0];
  assign stall_req_o = (ce_ram_i && (state == IDLE)) || (state == REQ) || (state == RESP);

`ifdef DMEM_MISALIGN_CHK_EN
  logic misalign_q;

  // Natural alignment required for half, word and double accesses.
  assign misaligned_c = ((mem_sel_i == 8'h03) && addr_c[0]) ||
                        ((mem_sel_i == 8'h0F) && (addr_c[1:0] != 2'b00)) ||
                        ((mem_sel_i == 8'hFF) && (addr_c[2:0] != 3'b000));
  assign misalign_o   = misalign_q;
`else
  assign misaligned_c = 1'b0;
  assign misalign_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      off            <= 3'b000;
      bus_valid_o    <= 1'b0;
      bus_we_o       <= 1'b0;
      bus_addr_o     <= '0;
      bus_wdata_o    <= '0;
      bus_wstrb_o    <= 8'h00;
      mem_data_ram_o <= '0;
      err_o          <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
      misalign_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ce_ram_i) begin
`ifdef DMEM_MISALIGN_CHK_EN
            misalign_q <= misaligned_c;
`endif
            if (misaligned_c) begin
              err_o          <= 1'b1;
              mem_data_ram_o <= '0;
              state          <= DONE;
            end else begin
              off         <= req_off_c;
              bus_addr_o  <= {addr_c[ADDR_W-1:3], 3'b000};
              bus_wdata_o <= mem_data_i << {req_off_c, 3'b000};
              bus_wstrb_o <= mem_sel_i << req_off_c;
              bus_we_o    <= ~mem_r_ena_i;
              bus_valid_o <= 1'b1;
              err_o       <= 1'b0;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_ready_i) begin
            bus_valid_o <= 1'b0;
            cnt         <= '0;
            state       <= RESP;
          end
        end
        RESP: begin
          // A response on the last allowed cycle still completes normally.
          if (bus_rvalid_i) begin
            mem_data_ram_o <= bus_rdata_i >> {off, 3'b000};
            state          <= DONE;
          end else if (cnt == CNT_LAST) begin
            err_o          <= 1'b1;
            mem_data_ram_o <= '0;
            state          <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!hold_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
